// File: rtl/resp_window_checker.sv
`default_nettype none
// ============================================================================
// resp_window_checker : per-channel stimulus->response window and ordering checker
// Revision 1.0
// ============================================================================
module resp_window_checker #(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 8,
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 3,
  parameter int ORD_LE  = 0,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH*WIDTH-1:0] a,
  input  logic [N_CH*WIDTH-1:0] b,
  input  logic                  clr,
  output logic [N_CH-1:0]       err_timeout,
  output logic [N_CH-1:0]       err_early,
  output logic [N_CH-1:0]       err_order,
  output logic [N_CH-1:0]       err_sticky,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam int PC_W  = $clog2(3*N_CH+1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  logic [N_CH*WIDTH-1:0] a_q, b_q;
  logic                  primed_q;
  logic [N_CH-1:0]       timeout_d, early_d, order_d;
  logic [N_CH-1:0]       timeout_q, early_q, order_q, sticky_q;
  logic [CNT_W-1:0]      errcnt_q, errcnt_d, errcnt_base;
  logic [PC_W-1:0]       pulse_cnt;
  logic [SUM_W-1:0]      errcnt_sum;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [WIDTH-1:0] a_cur, b_cur;
    logic             a_chg, b_chg, dly_ge_min, dly_at_max;
    state_t           state_q;
    logic [7:0]       dly_q;

    assign a_cur      = a[i*WIDTH +: WIDTH];
    assign b_cur      = b[i*WIDTH +: WIDTH];
    assign a_chg      = primed_q && (a_cur != a_q[i*WIDTH +: WIDTH]);
    assign b_chg      = primed_q && (b_cur != b_q[i*WIDTH +: WIDTH]);
    assign dly_ge_min = (dly_q >= 8'(MIN_DLY));
    assign dly_at_max = (dly_q == 8'(MAX_DLY));

    // A response on the same edge as the deadline counts as a pass, not a timeout.
    assign timeout_d[i] = en[i] && (state_q == S_WAIT) && !b_chg && dly_at_max;
    assign early_d[i]   = en[i] && (state_q == S_WAIT) && b_chg && !dly_ge_min;

    if (ORD_LE != 0) begin : g_ord_le
      assign order_d[i] = en[i] && primed_q && (a_cur > b_cur);
    end else begin : g_ord_lt
      assign order_d[i] = en[i] && primed_q && (a_cur >= b_cur);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_IDLE;
        dly_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (en[i] && a_chg) begin
              state_q <= S_WAIT;
              dly_q   <= 8'd1;
            end
          end
          S_WAIT: begin
            if (!en[i] || b_chg || dly_at_max) begin
              state_q <= S_IDLE;
              dly_q   <= '0;
            end else begin
              dly_q <= dly_q + 8'd1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            dly_q   <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    pulse_cnt   = PC_W'($countones({timeout_d, early_d, order_d}));
    errcnt_base = clr ? '0 : errcnt_q;
    errcnt_sum  = SUM_W'(errcnt_base) + SUM_W'(pulse_cnt);
    if (errcnt_sum > SUM_W'({CNT_W{1'b1}})) begin
      errcnt_d = '1;
    end else begin
      errcnt_d = errcnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      primed_q  <= 1'b0;
      timeout_q <= '0;
      early_q   <= '0;
      order_q   <= '0;
      sticky_q  <= '0;
      errcnt_q  <= '0;
    end else begin
      a_q       <= a;
      b_q       <= b;
      primed_q  <= 1'b1;
      timeout_q <= timeout_d;
      early_q   <= early_d;
      order_q   <= order_d;
      // Errors detected on the clearing edge survive the clear.
      sticky_q  <= (clr ? '0 : sticky_q) | timeout_d | early_d | order_d;
      errcnt_q  <= errcnt_d;
    end
  end

  assign err_timeout = timeout_q;
  assign err_early   = early_q;
  assign err_order   = order_q;
  assign err_sticky  = sticky_q;
  assign err_cnt     = errcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_resp_window_checker.sv
`default_nettype none
// ============================================================================
// tb_resp_window_checker : two checker configurations against a timestamp model
// Revision 1.0
// ============================================================================
module tb_resp_window_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en;
  logic [15:0] a, b;
  logic        clr;

  logic [1:0]  to1, ea1, or1, st1;
  logic [4:0]  cnt1;
  logic [1:0]  to2, ea2, or2, st2;
  logic [5:0]  cnt2;

  int n_chk  = 0;
  int n_pass = 0;

  // model state: index [cfg][ch]; pend holds the trigger edge number or -1
  int       pend [2][2];
  bit [1:0] e_to [2];
  bit [1:0] e_ea [2];
  bit [1:0] e_or [2];
  bit [1:0] e_st [2];
  int       e_cnt[2];
  int       pa[2], pb[2];
  int       edges;

  always #5 clk = ~clk;

  resp_window_checker #(.N_CH(2), .WIDTH(8), .MIN_DLY(1), .MAX_DLY(3), .ORD_LE(0), .CNT_W(5)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .clr(clr),
    .err_timeout(to1), .err_early(ea1), .err_order(or1), .err_sticky(st1), .err_cnt(cnt1));

  resp_window_checker #(.N_CH(2), .WIDTH(8), .MIN_DLY(2), .MAX_DLY(4), .ORD_LE(1), .CNT_W(6)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .clr(clr),
    .err_timeout(to2), .err_early(ea2), .err_order(or2), .err_sticky(st2), .err_cnt(cnt2));

  function automatic int cfg_min(int c);  return (c == 0) ? 1 : 2;   endfunction
  function automatic int cfg_max(int c);  return (c == 0) ? 3 : 4;   endfunction
  function automatic int cfg_cmax(int c); return (c == 0) ? 31 : 63; endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int ch = 0; ch < 2; ch++) pend[c][ch] = -1;
      e_to[c] = '0; e_ea[c] = '0; e_or[c] = '0; e_st[c] = '0; e_cnt[c] = 0;
    end
    pa[0] = 0; pa[1] = 0; pb[0] = 0; pb[1] = 0;
    edges = 0;
  endtask

  // One rising edge as seen by the rules: delay = edge number minus trigger edge number.
  task automatic model_edge();
    bit primed, achg, bchg, viol;
    int ai, bi, d, tot;
    primed = (edges >= 1);
    for (int c = 0; c < 2; c++) begin
      e_to[c] = '0; e_ea[c] = '0; e_or[c] = '0;
      for (int ch = 0; ch < 2; ch++) begin
        ai   = int'(a[ch*8 +: 8]);
        bi   = int'(b[ch*8 +: 8]);
        achg = primed && (ai != pa[ch]);
        bchg = primed && (bi != pb[ch]);
        viol = (c == 1) ? (ai > bi) : (ai >= bi);
        if (en[ch] && primed && viol) e_or[c][ch] = 1'b1;
        if (pend[c][ch] >= 0) begin
          d = edges - pend[c][ch];
          if (!en[ch]) pend[c][ch] = -1;
          else if (bchg) begin
            if (d < cfg_min(c)) e_ea[c][ch] = 1'b1;
            pend[c][ch] = -1;
          end else if (d == cfg_max(c)) begin
            e_to[c][ch] = 1'b1;
            pend[c][ch] = -1;
          end
        end else if (en[ch] && achg) begin
          pend[c][ch] = edges;
        end
      end
      tot      = $countones({e_to[c], e_ea[c], e_or[c]});
      e_st[c]  = (clr ? 2'b00 : e_st[c]) | e_to[c] | e_ea[c] | e_or[c];
      e_cnt[c] = (clr ? 0 : e_cnt[c]) + tot;
      if (e_cnt[c] > cfg_cmax(c)) e_cnt[c] = cfg_cmax(c);
    end
    for (int ch = 0; ch < 2; ch++) begin
      pa[ch] = int'(a[ch*8 +: 8]);
      pb[ch] = int'(b[ch*8 +: 8]);
    end
    edges++;
  endtask

  task automatic check_all();
    chk("d0_timeout", 32'(to1),  32'(e_to[0]));
    chk("d0_early",   32'(ea1),  32'(e_ea[0]));
    chk("d0_order",   32'(or1),  32'(e_or[0]));
    chk("d0_sticky",  32'(st1),  32'(e_st[0]));
    chk("d0_cnt",     32'(cnt1), 32'(e_cnt[0]));
    chk("d1_timeout", 32'(to2),  32'(e_to[1]));
    chk("d1_early",   32'(ea2),  32'(e_ea[1]));
    chk("d1_order",   32'(or2),  32'(e_or[1]));
    chk("d1_sticky",  32'(st2),  32'(e_st[1]));
    chk("d1_cnt",     32'(cnt2), 32'(e_cnt[1]));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    step();
    step();
    rst = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = '0; a = '0; b = '0; clr = 1'b0;
    model_reset();
    step();
    step();
    rst = 1'b0;

    // pass inside the window
    en = 2'b01; a = 16'h0000; b = 16'h0006;
    step(); step();
    a[7:0] = 8'd5; step(); step();
    b[7:0] = 8'd9; step(); step();
    chk("pass_cnt", 32'(cnt1), 32'd0);
    chk("pass_to",  32'(to1),  32'd0);

    // timeout after MAX_DLY edges
    a[7:0] = 8'd7; step();
    step(); step(); step();
    chk("tmo_pulse",  32'(to1),  32'd1);
    chk("tmo_sticky", 32'(st1),  32'd1);
    chk("tmo_cnt",    32'(cnt1), 32'd1);
    step();
    chk("tmo_one_cycle", 32'(to1), 32'd0);
    clr = 1'b1; step(); clr = 1'b0;

    // ordering violations on ch1, then clear
    en = 2'b10; a[15:8] = 8'd10; b[15:8] = 8'd4;
    step(); step(); step();
    chk("ord_pulse",  32'(or1),  32'd2);
    chk("ord_cnt",    32'(cnt1), 32'd3);
    chk("ord_sticky", 32'(st1),  32'd2);
    en = 2'b00; clr = 1'b1; step(); clr = 1'b0;
    chk("clr_sticky", 32'(st1),  32'd0);
    chk("clr_cnt",    32'(cnt1), 32'd0);

    // two timeouts plus an ordering error on one edge, then saturation
    b[15:8] = 8'd20; step();
    en = 2'b11; a[7:0] = 8'd8; a[15:8] = 8'd11; step();
    step(); step();
    a[7:0] = 8'd50; step();
    chk("multi_to",  32'(to1),  32'd3);
    chk("multi_ord", 32'(or1),  32'd1);
    chk("multi_cnt", 32'(cnt1), 32'd3);
    a = 16'hC8C8; b = 16'h0000;
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt", 32'(cnt1), 32'd31);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_load_cnt",    32'(cnt1), 32'd2);
    chk("clr_keep_sticky", 32'(st1),  32'd3);

    // reset while waiting discards the check
    en = 2'b01; a = 16'h0001; b = 16'h0009;
    for (int i = 0; i < 5; i++) step();
    a[7:0] = 8'd2; step(); step();
    do_reset();
    a[7:0] = 8'd3; step();
    for (int i = 0; i < 4; i++) step();
    chk("rst_cnt",    32'(cnt1), 32'd0);
    chk("rst_sticky", 32'(st1),  32'd0);

    // retrigger inside the window is ignored; disable aborts silently
    a[7:0] = 8'd4; step();
    a[7:0] = 8'd5; step();
    step();
    b[7:0] = 8'd10; step(); step();
    chk("retrig_cnt", 32'(cnt1), 32'd0);
    a[7:0] = 8'd6; step();
    en = 2'b00; step();
    for (int i = 0; i < 4; i++) step();
    chk("abort_cnt", 32'(cnt1), 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        for (int ch = 0; ch < 2; ch++) begin
          en[ch] = ($urandom_range(0, 7) != 0);
          if ($urandom_range(0, 3) == 0) a[ch*8 +: 8] = 8'($urandom_range(0, 15));
          if ($urandom_range(0, 3) == 0) b[ch*8 +: 8] = 8'($urandom_range(0, 15));
        end
        clr = ($urandom_range(0, 29) == 0);
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
